// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter fed by a small byte FIFO.
//
// Frames are start bit (0), eight data bits LSB first, and one stop bit (1).
// Every bit is held for CLKS_PER_BIT cycles. When the FIFO still holds a byte
// at the end of a stop bit, the next frame starts on that same edge, so there
// is no idle gap between frames.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//   FIFO_DEPTH    byte FIFO entries (power of two, >= 2)
// Ports:
//   clk         sole clock, rising edge
//   reset       synchronous, active-high reset
//   tx_data_i   byte to send
//   tx_valid_i  tx_data_i is valid; pushed when tx_ready_o is also high
//   tx_ready_o  FIFO can accept a byte (not full); independent of tx_valid_i
//   txd_o       registered serial line, idle high
//   busy_o      a frame is in progress or the FIFO is non-empty
module uart_tx #(
  parameter int CLKS_PER_BIT = 234,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       txd_o,
  output logic       busy_o
);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e                     state_q, state_d;
  logic [FIFO_DEPTH-1:0][7:0] mem_q, mem_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [BAUD_W-1:0]          baud_q, baud_d;
  logic [2:0]                 bit_q, bit_d;
  logic [7:0]                 shift_q, shift_d;
  logic                       txd_q, txd_d;

  logic push, pop, fifo_nempty, bit_end;

  assign fifo_nempty = (count_q != '0);
  assign bit_end     = (baud_q == BAUD_LAST);
  assign tx_ready_o  = (count_q != CNT_FULL);
  assign push        = tx_valid_i && tx_ready_o;
  assign txd_o       = txd_q;
  assign busy_o      = (state_q != S_IDLE) || fifo_nempty;

  // State register plus all datapath flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by count/pointers alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // FIFO bookkeeping. Pointers wrap naturally since the depth is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = tx_data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fifo_nempty)                state_d = S_START;
      S_START: if (bit_end)                    state_d = S_DATA;
      S_DATA:  if (bit_end && bit_q == 3'd7)   state_d = S_STOP;
      S_STOP:  if (bit_end)                    state_d = fifo_nempty ? S_START : S_IDLE;
      default:                                 state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic. txd is registered, so each value is computed one
  // cycle ahead of the bit it belongs to.
  always_comb begin
    pop     = 1'b0;
    txd_d   = txd_q;
    baud_d  = bit_end ? '0 : baud_q + BAUD_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        txd_d  = 1'b1;
        baud_d = '0;
        if (fifo_nempty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          txd_d = shift_q[0];
          bit_d = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            txd_d = 1'b1;
          end else begin
            // shift_q[0] is the bit now on the line; the next one sits above it.
            txd_d   = shift_q[1];
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (bit_end && fifo_nempty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          txd_d   = 1'b0;
        end
      end
      default: begin
        txd_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx. Instance A runs with a 4-cycle bit period, instance B
// with the default 234-cycle period. Stimulus pushes expected bytes into a
// per-instance queue; a UART line decoder per instance reconstructs frames
// from txd and compares them against the queue head.
module tb_uart_tx;
  localparam int CPB_A = 4;
  localparam int CPB_B = 234;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_a = '0, data_b = '0;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       ready_a, txd_a, busy_a;
  logic       ready_b, txd_b, busy_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit abort_a = 1'b0;
  int dec_b = 0;
  int last_wait = 0;

  logic [7:0] exp_a[$], exp_b[$];
  int         start_a[$], start_b[$];

  uart_tx #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .tx_data_i(data_a), .tx_valid_i(valid_a),
    .tx_ready_o(ready_a), .txd_o(txd_a), .busy_o(busy_a));

  uart_tx #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .tx_data_i(data_b), .tx_valid_i(valid_b),
    .tx_ready_o(ready_b), .txd_o(txd_b), .busy_o(busy_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[b-1];
  endfunction

  function automatic logic line(input int w);
    return (w == 0) ? txd_a : txd_b;
  endfunction

  // Line decoder: a falling line starts a frame; each of the 10 bit cells must
  // be constant for the whole bit period, with start=0 and stop=1.
  task automatic mon(input int w);
    int         cpb;
    logic [9:0] cells;
    logic       s, glitch;
    logic [7:0] exp;
    cpb = (w == 0) ? CPB_A : CPB_B;
    forever begin
      @(negedge clk);
      if (mon_en && line(w) == 1'b0) begin
        if (w == 0) start_a.push_back(cyc); else start_b.push_back(cyc);
        glitch = 1'b0;
        cells  = '0;
        for (int b = 0; b < 10; b++) begin
          for (int j = 0; j < cpb; j++) begin
            if (!(b == 0 && j == 0)) @(negedge clk);
            s = line(w);
            if (j == 0) cells[b] = s;
            else if (s != cells[b]) glitch = 1'b1;
          end
        end
        if (w == 0 && abort_a) begin
          abort_a = 1'b0;
        end else begin
          chk(w == 0 ? "frame_shape_a" : "frame_shape_b",
              {glitch, cells[0], cells[9]}, 3'b001);
          if ((w == 0 ? exp_a.size() : exp_b.size()) == 0) begin
            chk(w == 0 ? "unexpected_frame_a" : "unexpected_frame_b", cells[8:1], -1);
          end else begin
            exp = (w == 0) ? exp_a.pop_front() : exp_b.pop_front();
            chk(w == 0 ? "byte_a" : "byte_b", cells[8:1], exp);
            if (w == 1) dec_b++;
          end
        end
      end
    end
  endtask

  // Holds valid (driven at negedge) until ready was seen with it; records the
  // byte as expected once the accepting edge has passed.
  task automatic push(input int w, input logic [7:0] d);
    logic acc;
    int   n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 10000) begin
      @(negedge clk);
      if (w == 0) begin data_a = d; valid_a = 1'b1; acc = ready_a; end
      else        begin data_b = d; valid_b = 1'b1; acc = ready_b; end
      @(posedge clk);
      n++;
    end
    last_wait = n;
    if (!acc) chk("push_timeout", 0, 1);
    else if (w == 0) exp_a.push_back(d);
    else exp_b.push_back(d);
  endtask

  task automatic idle_in(input int w);
    @(negedge clk);
    if (w == 0) valid_a = 1'b0; else valid_b = 1'b0;
  endtask

  task automatic drain(input int w, input int limit);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
      if (w == 0) done = (exp_a.size() == 0) && !busy_a;
      else        done = (exp_b.size() == 0) && !busy_b;
    end
    chk(w == 0 ? "drain_a" : "drain_b", done, 1);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] t3 [5];
    int   base, sum, bad, gap;
    logic prev, got, seen_full, ok;

    fork
      mon(0);
      mon(1);
    join_none

    // 1. Reset with random inputs; coincident pushes must be dropped.
    repeat (2) begin
      @(negedge clk);
      valid_a = 1'($urandom); data_a = 8'($urandom);
      valid_b = 1'($urandom); data_b = 8'($urandom);
    end
    @(negedge clk);
    reset = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    chk("rst_txd_a", txd_a, 1);
    chk("rst_ready_a", ready_a, 1);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_state_b", {txd_b, ready_b, busy_b}, 3'b110);
    mon_en = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (txd_a !== 1'b1 || txd_b !== 1'b1 || busy_a || busy_b) bad++;
    end
    chk("rst_quiet_50", bad, 0);

    // 2. Single byte 0xA5: exact line waveform and busy fall at t0+41.
    push(0, 8'hA5);
    idle_in(0);
    for (int b = 0; b < 10; b++) begin
      ok = 1'b1;
      for (int j = 0; j < CPB_A; j++) begin
        @(negedge clk);
        if (txd_a !== frame_bit(8'hA5, b)) ok = 1'b0;
        if (b == 9 && j == CPB_A - 1) chk("t2_busy_last_stop", busy_a, 1);
      end
      chk($sformatf("t2_bit%0d", b), ok, 1);
    end
    @(negedge clk);
    chk("t2_busy_t0p41", busy_a, 0);
    drain(0, 200);

    // 3. Back-to-back stream. The first byte leaves the FIFO on the edge after
    // it is pushed, so ready drops once FIFO_DEPTH more bytes are held.
    t3 = '{8'h00, 8'hFF, 8'h55, 8'h3C, 8'h81};
    base = start_a.size();
    sum = 0;
    for (int i = 0; i < 5; i++) begin
      push(0, t3[i]);
      sum += last_wait;
    end
    chk("t3_no_stall", sum, 5);
    @(negedge clk);
    chk("t3_ready_full", ready_a, 0);
    chk("t3_busy_full", busy_a, 1);
    valid_a = 1'b0;
    drain(0, 400);
    chk("t3_frames", start_a.size() - base, 5);
    if (start_a.size() - base == 5)
      for (int k = 1; k < 5; k++)
        chk($sformatf("t3_spacing%0d", k), start_a[base+k] - start_a[base+k-1], 10 * CPB_A);

    // 4. Push into a full FIFO on the cycle of a pop: refused, then accepted.
    for (int i = 0; i < 5; i++) push(0, 8'($urandom));
    d = 8'($urandom);
    prev = 1'b1; got = 1'b0; seen_full = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      data_a = d; valid_a = 1'b1;
      if (!ready_a) seen_full = 1'b1;
      else begin
        got = 1'b1;
        // ready returns right after the pop, i.e. as the next start bit begins.
        chk("t4_ready_after_pop", {prev, txd_a}, 2'b10);
      end
      prev = txd_a;
    end
    chk("t4_seen_full", seen_full, 1);
    chk("t4_accepted", got, 1);
    if (got) begin
      @(posedge clk);
      exp_a.push_back(d);
    end
    idle_in(0);
    drain(0, 400);

    // 5. Reset during data bit 3 of 0x0F with two bytes queued.
    push(0, 8'h0F);
    push(0, 8'($urandom));
    push(0, 8'($urandom));
    idle_in(0);
    repeat (15) @(negedge clk);
    chk("t5_pre_bit3", {busy_a, txd_a}, 2'b11);
    base = start_a.size();
    abort_a = 1'b1;
    reset = 1'b1; valid_a = 1'b1; data_a = 8'h77;
    @(negedge clk);
    reset = 1'b0; valid_a = 1'b0;
    exp_a.delete();
    chk("t5_txd_after_rst", txd_a, 1);
    chk("t5_busy_after_rst", busy_a, 0);
    chk("t5_ready_after_rst", ready_a, 1);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd_a !== 1'b1 || busy_a) bad++;
    end
    chk("t5_quiet", bad, 0);
    chk("t5_no_new_frames", start_a.size() - base, 0);

    // 6. 20 random bytes at 234 clocks per bit with random valid gaps.
    for (int i = 0; i < 20; i++) begin
      push(1, 8'($urandom));
      if ($urandom_range(0, 2) != 0) begin
        gap = $urandom_range(1, 400);
        idle_in(1);
        repeat (gap) @(negedge clk);
      end
    end
    idle_in(1);
    drain(1, 30000);
    chk("t6_decoded", dec_b, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
